binary_downcounter: RTL and testbench
=====================================

# binary_downcounter

Parameterised loadable binary down-counter with a ripple-borrow chain, combinational underflow output and a registered terminal-count pulse. It is the decrementing counterpart of the team's binary up-counter and serves as a programmable timer and divider inside peripheral blocks. Typical uses are baud dividers, timeouts and PWM period generation. Optional auto-reload turns it into a free-running period generator.

## Interface
- BITS, default 8: counter width; legal range ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ena  in  1  count enable; decrement by one per clk while high.
- load  in  1  synchronous load of `value`; priority over ena.
- value  in  BITS  load value.
- out  out  BITS  current count.
- zero  out  1  combinational, high when out == 0.
- udf  out  1  combinational underflow/borrow-out; high when ena & ~load & out == 0.
- tc  out  1  registered copy of udf; one-cycle pulse, the cycle after an underflow.

## Operation
- Borrow chain: b[0] = ena & ~load; b[i+1] = ~cnt[i] & b[i]; udf = b[BITS].
- Each bit i toggles when b[i] is high, so no full-width subtractor is used.
- Priority per cycle: rst (async) > load > count > hold.
- load: cnt <= value; no decrement that cycle; udf held low.
- count, cnt != 0: cnt <= cnt - 1.
- count, cnt == 0, without reload: cnt wraps to 2^BITS-1; udf high that cycle.
- count, cnt == 0, with reload (see Configuration): cnt <= reload_q; udf high that cycle.
- ena low: cnt holds; udf low.
- Reset values: out = 0, zero = 1, udf = 0 unless ena is high (ena high at reset release → udf high on the first cycle), tc = 0, reload_q = 0.
- Reset mid-count: immediate return to reset values; no tc pulse is generated for the aborted count.
- BITS = 1: behaves as a toggle with udf = ena & ~load & ~out[0].

## Timing
- load→out: 1 cycle; out shows `value` after the rising edge where load was sampled.
- Decrement latency: 1 cycle per enabled edge.
- udf is combinational from cnt, ena and load, in the same cycle as the wrapping edge.
- tc asserts 1 cycle after udf and lasts exactly 1 cycle per underflow.
- Continuous ena after load of N:
  - udf asserts in cycle N after the load edge, i.e. after N decrements.
  - Without reload, the period is 2^BITS thereafter.
  - With reload, the period is reload_q+1.
- Simultaneous load & ena at cnt == 0: load wins, udf stays low and tc does not fire next cycle.
- Critical path: BITS-deep AND chain; no pipelining required.

## Configuration
- Macro BINARY_DOWNCOUNTER_RELOAD_EN.
- Defined:
  - A BITS-wide reload_q register captures `value` on every load.
  - On underflow the count reloads from reload_q instead of wrapping.
  - reload_q resets to 0; with reload_q = 0 and continuous ena, udf is high every cycle.
- Undefined: reload_q is not instantiated and the count wraps to all-ones; ports are unchanged.

## Structure
- Shared package binary_counter_pkg:
  - width-check constant BC_MIN_BITS = 1;
  - localparam helper for the all-ones value;
  - the same package also serves the up-counter.
- One sub-module, downcounter_cell: a single T-flip-flop bit.
  - Inputs: clk, rst, load, load bit, borrow-in, reload bit.
  - Outputs: q, borrow-out.
  - Instantiated BITS times via generate.
- Top level contains only the generate loop, the zero reduction, udf/tc logic and the optional reload register.

## Test plan
- BITS=4, reset released, ena=0 → out=0, zero=1, udf=0, tc=0; pulse rst low mid-count at out=5 → out=0 asynchronously, no tc.
- load value=3, then ena=1 continuous → out 3,2,1,0,15,14; udf high only while out=0; tc high in the cycle out=15.
- BINARY_DOWNCOUNTER_RELOAD_EN, load 2, ena continuous → out 2,1,0,2,1,0; udf at each 0, tc one cycle later; period 3.
- out=0, load=1 with value=9 and ena=1 in the same cycle → out=9, udf=0, tc=0 next cycle.
- ena toggled 1,0,1 from out=1 → out 0, holds 0 with udf=0 while ena=0, then udf=1 and wraps (15, or reload_q with the macro).
- BITS=1, ena continuous from reset → out 0,1,0,1; udf high whenever out=0.

Source files
------------

// File: rtl/binary_counter_pkg.sv
// Shared definitions for the binary up/down counter family.
package binary_counter_pkg;

  localparam int unsigned BC_MIN_BITS = 1;

  // All-ones pattern for a counter of the given width (up to 64 bits).
  function automatic logic [63:0] bc_all_ones(input int unsigned bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

endpackage

// File: rtl/downcounter_cell.sv
// One bit of the ripple-borrow down-counter: a T flip-flop with load and wrap/reload.
module downcounter_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_bit,
  input  logic borrow_in,
  input  logic wrap,
  input  logic reload_bit,
  output logic q,
  output logic borrow_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_bit;
    end else if (wrap) begin
      q <= reload_bit;
    end else if (borrow_in) begin
      q <= ~q;
    end
  end

  assign borrow_out = ~q & borrow_in;

endmodule

// File: rtl/binary_downcounter.sv
// Loadable ripple-borrow down-counter with underflow and registered terminal count.
// Define BINARY_DOWNCOUNTER_RELOAD_EN to reload from the last loaded value on underflow.
module binary_downcounter
  import binary_counter_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            load,
  input  logic [BITS-1:0] value,
  output logic [BITS-1:0] out,
  output logic            zero,
  output logic            udf,
  output logic            tc
);

  if (BITS < BC_MIN_BITS) begin : g_bad_width
    $error("binary_downcounter: BITS must be at least 1");
  end

  logic [BITS:0]   borrow;
  logic [BITS-1:0] cnt;
  logic [BITS-1:0] reload_val;
  logic            tc_q;

  assign borrow[0] = ena & ~load;

  for (genvar i = 0; i < BITS; i++) begin : g_cell
    downcounter_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_bit   (value[i]),
      .borrow_in  (borrow[i]),
      .wrap       (udf),
      .reload_bit (reload_val[i]),
      .q          (cnt[i]),
      .borrow_out (borrow[i+1])
    );
  end

`ifdef BINARY_DOWNCOUNTER_RELOAD_EN
  logic [BITS-1:0] reload_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= value;
    end
  end

  assign reload_val = reload_q;
`else
  // Wrapping to all-ones is what the toggle chain produces anyway; kept explicit for symmetry.
  localparam logic [BITS-1:0] AllOnes = BITS'(bc_all_ones(BITS));
  assign reload_val = AllOnes;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= udf;
    end
  end

  assign udf  = borrow[BITS];
  assign zero = ~|cnt;
  assign out  = cnt;
  assign tc   = tc_q;

endmodule

// File: tb/tb_binary_downcounter.sv
// Directed scoreboard bench for binary_downcounter (BITS=4 and BITS=1 instances).
module tb_binary_downcounter;

`ifdef BINARY_DOWNCOUNTER_RELOAD_EN
  localparam bit Reload = 1'b1;
`else
  localparam bit Reload = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       load = 1'b0;
  logic [3:0] value = 4'd0;
  logic [3:0] out;
  logic       zero, udf, tc;

  logic       ena1 = 1'b1;
  logic       load1 = 1'b0;
  logic [0:0] value1 = 1'b0;
  logic [0:0] out1;
  logic       zero1, udf1, tc1;

  always #5 clk = ~clk;

  binary_downcounter #(.BITS(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .value(value),
    .out(out), .zero(zero), .udf(udf), .tc(tc)
  );

  binary_downcounter #(.BITS(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .load(load1), .value(value1),
    .out(out1), .zero(zero1), .udf(udf1), .tc(tc1)
  );

  typedef struct {
    logic [3:0] out;
    logic       zero;
    logic       udf;
    logic       tc;
    logic       out1;
    logic       udf1;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] m_cnt = 4'd0;
  logic [3:0] m_rel = 4'd0;
  logic       m_tc = 1'b0;
  logic       m1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check this cycle's outputs, advance model across the posedge.
  task automatic step(input logic e, input logic l, input logic [3:0] v);
    exp_t x;
    exp_t got;
    logic u;
    ena = e;
    load = l;
    value = v;
    u = e && !l && (m_cnt == 4'd0);
    x.out = m_cnt;
    x.zero = (m_cnt == 4'd0);
    x.udf = u;
    x.tc = m_tc;
    x.out1 = m1;
    x.udf1 = ~m1;
    sb.push_back(x);
    #1;
    got = sb.pop_front();
    check("out", 32'(out), 32'(got.out));
    check("zero", 32'(zero), 32'(got.zero));
    check("udf", 32'(udf), 32'(got.udf));
    check("tc", 32'(tc), 32'(got.tc));
    check("out1", 32'(out1), 32'(got.out1));
    check("udf1", 32'(udf1), 32'(got.udf1));
    if (l) begin
      m_cnt = v;
      m_rel = v;
    end else if (e) begin
      m_cnt = (m_cnt == 4'd0) ? (Reload ? m_rel : 4'hF) : m_cnt - 4'd1;
    end
    m_tc = u;
    m1 = ~m1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Reset state, idle, and BITS=1 toggling with ena high from release.
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);

    // Load 8, count to 5, then abort with an asynchronous reset.
    step(1'b0, 1'b1, 4'd8);
    repeat (3) step(1'b1, 1'b0, 4'd0);
    ena = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    m_cnt = 4'd0;
    m_rel = 4'd0;
    m_tc = 1'b0;
    m1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 4'd0);

    // Load 3, continuous count through underflow.
    step(1'b0, 1'b1, 4'd3);
    repeat (6) step(1'b1, 1'b0, 4'd0);

    // Run to zero, then load and ena together at zero.
    step(1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);

    // ena 1,0,1 from out=1.
    step(1'b0, 1'b1, 4'd1);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);

    // Load 2, continuous: reload period 3, or wrap without reload.
    step(1'b0, 1'b1, 4'd2);
    repeat (8) step(1'b1, 1'b0, 4'd0);

    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
